issue_queue_ctrl: RTL and testbench

// - Buffers decoded LoongArch instructions (PC_set) from the two ID decoders in an in-order circular queue.
// - Selects 0/1/2 instructions per cycle for the A/B execution channels.
// - Enforces intra-pair RAW, one-mem-op-per-pair, branch-in-A and load-use rules; drains on pipeline flush.
// - Sits between ID decode and the EX/MEM channels; the only sequencer of that datapath.

---
 rtl/issue_queue_ctrl.sv | 137 +++++++++++++
 tb/tb_issue_queue_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_ctrl.sv
// In-order issue queue between ID decode and the A/B execution channels.
// Define DUAL_ISSUE_EN to enable channel B pairing; otherwise issue is single through A.
package issue_queue_pkg;
    typedef struct packed {
        logic        o_valid;
        logic [31:0] pc;
        logic [3:0]  br_type;
        logic [1:0]  inst_type;
        logic        wb_sel;
        logic        rf_we;
        logic [4:0]  rf_rd;
        logic [4:0]  rf_raddr1;
        logic [4:0]  rf_raddr2;
    } PC_set;
endpackage

module issue_queue_ctrl
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  PC_set          in_set0,
    input  PC_set          in_set1,
    input  logic           in_valid0,
    input  logic           in_valid1,
    output logic           in_ready,
    input  logic           ex_ready,
    output PC_set          issue_a,
    output PC_set          issue_b,
    output logic           issue_valid_a,
    output logic           issue_valid_b,
    output logic [PTR_W:0] q_count
);

    localparam logic [PTR_W:0] PUSH_LIMIT = (PTR_W + 1)'(DEPTH - 2);

    PC_set            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             ld_track_valid;
    logic [4:0]       ld_track_rd;
    logic             push;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic             cand_a;
    logic             cand_b;
    PC_set            head;
    PC_set            second;

    function automatic logic ld_hazard(input PC_set x, input logic tv, input logic [4:0] trd);
        return tv & (trd != 5'd0) & ((x.rf_raddr1 == trd) | (x.rf_raddr2 == trd));
    endfunction

    function automatic logic is_load(input PC_set x);
        return x.wb_sel & x.rf_we;
    endfunction

    // Ready comes from the registered count, so a push at DEPTH-2 is legal even with no pop.
    assign in_ready = (count <= PUSH_LIMIT);
    assign push     = in_ready & in_valid0 & ~flush;
    assign push_n   = push ? (in_valid1 ? 2'd2 : 2'd1) : 2'd0;

    assign head    = mem[rd_ptr];
    assign second  = mem[rd_ptr + PTR_W'(1)];
    assign issue_a = head;
    assign issue_b = second;
    assign q_count = count;

    always_comb begin
        cand_a        = (count != '0) & ~ld_hazard(head, ld_track_valid, ld_track_rd);
        issue_valid_a = cand_a & ex_ready & ~flush;
    end

`ifdef DUAL_ISSUE_EN
    // B pairs with A only when it cannot observe A's result or contend for the memory port.
    always_comb begin
        cand_b = issue_valid_a
               & (count >= (PTR_W + 1)'(2))
               & (head.br_type == 4'd0)
               & ~(head.rf_we & (head.rf_rd != 5'd0)
                   & ((second.rf_raddr1 == head.rf_rd) | (second.rf_raddr2 == head.rf_rd)))
               & ~(head.inst_type[1] & second.inst_type[1])
               & ~ld_hazard(second, ld_track_valid, ld_track_rd);
    end
`else
    assign cand_b = 1'b0;
`endif

    assign issue_valid_b = cand_b;
    assign pop_n = {1'b0, issue_valid_a} + {1'b0, issue_valid_b};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            ld_track_valid <= 1'b0;
            ld_track_rd    <= 5'd0;
        end else if (flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            ld_track_valid <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push_n);
            rd_ptr <= rd_ptr + PTR_W'(pop_n);
            count  <= count + (PTR_W + 1)'(push_n) - (PTR_W + 1)'(pop_n);
            // The youngest issued load is the one a following instruction must wait on.
            if (ex_ready) begin
                if (issue_valid_b & is_load(second)) begin
                    ld_track_valid <= 1'b1;
                    ld_track_rd    <= second.rf_rd;
                end else if (issue_valid_a & is_load(head)) begin
                    ld_track_valid <= 1'b1;
                    ld_track_rd    <= head.rf_rd;
                end else begin
                    ld_track_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_set0;
            if (in_valid1) begin
                mem[wr_ptr + PTR_W'(1)] <= in_set1;
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// Scoreboard bench for issue_queue_ctrl: directed scenarios followed by random traffic.
module tb_issue_queue_ctrl;
    import issue_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int W     = $bits(PC_set);
`ifdef DUAL_ISSUE_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           flush;
    PC_set          in_set0;
    PC_set          in_set1;
    logic           in_valid0;
    logic           in_valid1;
    logic           in_ready;
    logic           ex_ready;
    PC_set          issue_a;
    PC_set          issue_b;
    logic           issue_valid_a;
    logic           issue_valid_b;
    logic [PTR_W:0] q_count;

    issue_queue_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_set0(in_set0), .in_set1(in_set1),
        .in_valid0(in_valid0), .in_valid1(in_valid1), .in_ready(in_ready),
        .ex_ready(ex_ready),
        .issue_a(issue_a), .issue_b(issue_b),
        .issue_valid_a(issue_valid_a), .issue_valid_b(issue_valid_b),
        .q_count(q_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int pc_ctr   = 32'h1c00_0000;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 branch
    function automatic PC_set mk(input int pc, input int kind, input int rd, input int rs1, input int rs2);
        PC_set s;
        s           = '0;
        s.o_valid   = 1'b1;
        s.pc        = pc;
        s.rf_raddr1 = 5'(rs1);
        s.rf_raddr2 = 5'(rs2);
        case (kind)
            1: begin s.rf_we = 1'b1; s.wb_sel = 1'b1; s.inst_type = 2'b10; s.rf_rd = 5'(rd); end
            2: begin s.inst_type = 2'b11; end
            3: begin s.br_type = 4'd1; end
            default: begin s.rf_we = 1'b1; s.rf_rd = 5'(rd); end
        endcase
        return s;
    endfunction

    function automatic PC_set nxt(input int kind, input int rd, input int rs1, input int rs2);
        pc_ctr += 4;
        return mk(pc_ctr, kind, rd, rs1, rs2);
    endfunction

    // reference model: queue of accepted instructions plus the load tracker
    logic [W-1:0] exp_q[$];
    bit           trk_v;
    logic [4:0]   trk_rd;
    PC_set        m_a;
    PC_set        m_b;
    int           m_n;
    bit           e_a, e_b, e_rdy;

    function automatic bit m_haz(input PC_set x);
        return trk_v && trk_rd != 0 && (x.rf_raddr1 == trk_rd || x.rf_raddr2 == trk_rd);
    endfunction

    // monitor: inputs are stable at negedge, so the model decides this cycle and advances here
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_q_count", 64'(q_count), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_valid_a", 64'(issue_valid_a), 64'd0);
            chk("rst_valid_b", 64'(issue_valid_b), 64'd0);
            exp_q.delete();
            trk_v  = 1'b0;
            trk_rd = 5'd0;
        end else begin
            m_n   = exp_q.size();
            e_rdy = (DEPTH - m_n) >= 2;
            e_a   = 1'b0;
            e_b   = 1'b0;
            if (m_n >= 1) begin
                m_a = PC_set'(exp_q[0]);
                e_a = ex_ready && !flush && !m_haz(m_a);
            end
            if (DUAL && e_a && m_n >= 2) begin
                m_b = PC_set'(exp_q[1]);
                e_b = (m_a.br_type == 0)
                   && !(m_a.rf_we && m_a.rf_rd != 0
                        && (m_b.rf_raddr1 == m_a.rf_rd || m_b.rf_raddr2 == m_a.rf_rd))
                   && !(m_a.inst_type[1] && m_b.inst_type[1])
                   && !m_haz(m_b);
            end
            chk("q_count", 64'(q_count), 64'(m_n));
            chk("in_ready", 64'(in_ready), 64'(e_rdy));
            chk("valid_a", 64'(issue_valid_a), 64'(e_a));
            chk("valid_b", 64'(issue_valid_b), 64'(e_b));
            if (e_a && issue_valid_a) chk("issue_a", 64'(issue_a), 64'(m_a));
            if (e_b && issue_valid_b) chk("issue_b", 64'(issue_b), 64'(m_b));
            if (e_a) void'(exp_q.pop_front());
            if (e_b) void'(exp_q.pop_front());
            if (flush) begin
                exp_q.delete();
                trk_v = 1'b0;
            end else begin
                if (ex_ready) begin
                    if (e_b && m_b.wb_sel && m_b.rf_we) begin
                        trk_v = 1'b1; trk_rd = m_b.rf_rd;
                    end else if (e_a && m_a.wb_sel && m_a.rf_we) begin
                        trk_v = 1'b1; trk_rd = m_a.rf_rd;
                    end else begin
                        trk_v = 1'b0;
                    end
                end
                if (e_rdy && in_valid0) begin
                    exp_q.push_back(in_set0);
                    if (in_valid1) exp_q.push_back(in_set1);
                end
            end
        end
    end

    // driver tasks
    task automatic step(input bit v0, input PC_set s0, input bit v1, input PC_set s1,
                        input bit er, input bit fl);
        in_valid0 = v0; in_set0 = s0;
        in_valid1 = v1; in_set1 = s1;
        ex_ready  = er; flush   = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit er);
        step(1'b0, '0, 1'b0, '0, er, 1'b0);
    endtask

    task automatic idle_check(input bit ea, input bit eb, input int ecnt, input string nm);
        in_valid0 = 1'b0; in_valid1 = 1'b0; ex_ready = 1'b1; flush = 1'b0;
        @(negedge clk);
        chk({nm, "_va"}, 64'(issue_valid_a), 64'(ea));
        chk({nm, "_vb"}, 64'(issue_valid_b), 64'(eb));
        chk({nm, "_cnt"}, 64'(q_count), 64'(ecnt));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q_count != 0; i++) idle(1'b1);
        chk("drain_done", 64'(q_count), 64'd0);
    endtask

    initial begin
        int cnt;
        bit eb;
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b0;
        in_valid0 = 1'b0; in_valid1 = 1'b0; in_set0 = '0; in_set1 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // independent pair
        step(1'b1, nxt(0, 4, 1, 2), 1'b1, nxt(0, 5, 3, 3), 1'b1, 1'b0);
        idle_check(1'b1, DUAL, 2, "pair");
        drain();

        // intra-pair RAW
        step(1'b1, nxt(0, 4, 1, 2), 1'b1, nxt(0, 6, 4, 1), 1'b1, 1'b0);
        idle_check(1'b1, 1'b0, 2, "raw_a");
        idle_check(1'b1, 1'b0, 1, "raw_b");
        drain();

        // load-use across consecutive pushes
        step(1'b1, nxt(1, 7, 2, 0), 1'b0, '0, 1'b1, 1'b0);
        step(1'b1, nxt(0, 8, 7, 1), 1'b0, '0, 1'b1, 1'b0);
        idle_check(1'b0, 1'b0, 1, "ld_use_stall");
        idle_check(1'b1, 1'b0, 1, "ld_use_issue");
        drain();

        // branch in A, then load A + store B
        step(1'b1, nxt(3, 0, 1, 2), 1'b1, nxt(0, 9, 3, 3), 1'b1, 1'b0);
        idle_check(1'b1, 1'b0, 2, "br_alone");
        idle_check(1'b1, 1'b0, 1, "br_next");
        step(1'b1, nxt(1, 10, 11, 0), 1'b1, nxt(2, 0, 12, 13), 1'b1, 1'b0);
        idle_check(1'b1, 1'b0, 2, "mem_pair");
        idle_check(1'b1, 1'b0, 1, "mem_next");
        drain();

        // fill to DEPTH-1 with EX stalled, then overflow attempt is ignored
        for (int i = 0; i < 3; i++)
            step(1'b1, nxt(0, 10 + 2 * i, 20, 21), 1'b1, nxt(0, 11 + 2 * i, 22, 23), 1'b0, 1'b0);
        step(1'b1, nxt(0, 16, 20, 21), 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(q_count), 64'(DEPTH - 1));
        step(1'b1, nxt(0, 17, 20, 21), 1'b1, nxt(0, 18, 20, 21), 1'b0, 1'b0);
        chk("full_ignored", 64'(q_count), 64'(DEPTH - 1));
        drain();

        // four independent instructions
        step(1'b1, nxt(0, 1, 2, 3), 1'b1, nxt(0, 4, 5, 6), 1'b0, 1'b0);
        step(1'b1, nxt(0, 7, 8, 9), 1'b1, nxt(0, 10, 11, 12), 1'b0, 1'b0);
        cnt = 4;
        while (cnt > 0) begin
            eb = DUAL;
            idle_check(1'b1, eb, cnt, "indep");
            cnt -= 1 + int'(eb);
        end

        // flush with 5 queued and a same-cycle push
        step(1'b1, nxt(0, 1, 2, 3), 1'b1, nxt(0, 4, 5, 6), 1'b0, 1'b0);
        step(1'b1, nxt(0, 7, 8, 9), 1'b1, nxt(0, 10, 11, 12), 1'b0, 1'b0);
        step(1'b1, nxt(0, 13, 14, 15), 1'b0, '0, 1'b0, 1'b0);
        step(1'b1, nxt(0, 16, 17, 18), 1'b1, nxt(0, 19, 20, 21), 1'b1, 1'b1);
        idle_check(1'b0, 1'b0, 0, "flush");

        // asynchronous reset mid-operation
        step(1'b1, nxt(1, 3, 1, 2), 1'b1, nxt(0, 4, 5, 6), 1'b0, 1'b0);
        step(1'b1, nxt(0, 7, 8, 9), 1'b1, nxt(0, 10, 11, 12), 1'b0, 1'b0);
        rst = 1'b1;
        idle_check(1'b0, 1'b0, 0, "async_rst");
        rst = 1'b0;

        // random traffic with small register pool to provoke hazards
        for (int i = 0; i < 400; i++) begin
            PC_set s0, s1;
            s0 = nxt($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            s1 = nxt($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            step($urandom_range(0, 9) < 7, s0, $urandom_range(0, 1) == 1, s1,
                 $urandom_range(0, 9) < 8, $urandom_range(0, 39) == 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
